// File: rtl/pc_gen_if.sv
// Fetch-side bundle of the program-counter generator: control inputs in, fetch request out.
// The master modport is the PC generator; the slave modport is the pipeline/memory side.
interface pc_gen_if #(
   parameter int ADDR_W = 32
);
   logic              hold;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_target;
   logic              fetch_ready;
   logic [ADDR_W-1:0] pc;
   logic              pc_valid;
   logic              epoch;
   logic              misalign_err;

   modport master (
      input  hold, redirect_valid, redirect_target, fetch_ready,
      output pc, pc_valid, epoch, misalign_err
   );

   modport slave (
      output hold, redirect_valid, redirect_target, fetch_ready,
      input  pc, pc_valid, epoch, misalign_err
   );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator with BOOT/RUN/HOLD sequencing, redirect epochs and a one-entry pending redirect.
// Define PC_ALIGN_CHECK_EN to trap misaligned redirect targets to TRAP_VEC; otherwise their low bits are cleared.
module pc_gen #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = {ADDR_W{1'b0}},
   parameter logic [ADDR_W-1:0] INC       = ADDR_W'(3'd4),
   parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(12'h100)
) (
   input  logic         clk,
   input  logic         rst_n,
   pc_gen_if.master     bus
);
   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

   localparam logic [ADDR_W-1:0] LOW_MASK = INC - ADDR_W'(1'b1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              pc_valid_q, pc_valid_d;
   logic              epoch_q, epoch_d;
   logic              misalign_q, misalign_d;
   logic              pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

   logic [ADDR_W-1:0] tgt_eff_s;
   logic              tgt_bad_s;

   // Resolve the redirect target into the address actually loaded and whether it trapped
`ifdef PC_ALIGN_CHECK_EN
   always_comb begin
      tgt_bad_s = |(bus.redirect_target & LOW_MASK);
      if (tgt_bad_s) begin
         tgt_eff_s = TRAP_VEC;
      end else begin
         tgt_eff_s = bus.redirect_target;
      end
   end
`else
   always_comb begin
      tgt_bad_s = 1'b0;
      tgt_eff_s = bus.redirect_target & ~LOW_MASK;
   end
`endif

   // Next-state logic; redirect always wins, then hold, then sequential advance
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pc_valid_d   = pc_valid_q;
      epoch_d      = epoch_q;
      misalign_d   = 1'b0;
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      case (state_q)
         BOOT: begin
            state_d    = RUN;
            pc_valid_d = 1'b1;
            if (bus.redirect_valid) begin
               pc_d       = tgt_eff_s;
               epoch_d    = ~epoch_q;
               misalign_d = tgt_bad_s;
            end else begin
               pc_d = pc_q;
            end
         end
         RUN: begin
            if (bus.redirect_valid) begin
               pc_d       = tgt_eff_s;
               epoch_d    = ~epoch_q;
               misalign_d = tgt_bad_s;
               if (bus.hold) begin
                  state_d      = HOLD;
                  pc_valid_d   = 1'b0;
                  pend_valid_d = 1'b0;
               end else begin
                  pc_valid_d = 1'b1;
               end
            end else if (bus.hold) begin
               state_d    = HOLD;
               pc_valid_d = 1'b0;
            end else if (bus.fetch_ready) begin
               pc_d = pc_q + INC;
            end else begin
               pc_d = pc_q;
            end
         end
         HOLD: begin
            if (!bus.hold) begin
               state_d      = RUN;
               pc_valid_d   = 1'b1;
               pend_valid_d = 1'b0;
               if (bus.redirect_valid) begin
                  pc_d       = tgt_eff_s;
                  epoch_d    = ~epoch_q;
                  misalign_d = tgt_bad_s;
               end else if (pend_valid_q) begin
                  pc_d = pend_addr_q;
               end else begin
                  pc_d = pc_q;
               end
            end else if (bus.redirect_valid) begin
               // Newest redirect overwrites any earlier one captured during this freeze
               pend_valid_d = 1'b1;
               pend_addr_d  = tgt_eff_s;
               epoch_d      = ~epoch_q;
               misalign_d   = tgt_bad_s;
            end else begin
               pc_d = pc_q;
            end
         end
         default: begin
            state_d    = BOOT;
            pc_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= BOOT;
         pc_q         <= RESET_VEC;
         pc_valid_q   <= 1'b0;
         epoch_q      <= 1'b0;
         misalign_q   <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= {ADDR_W{1'b0}};
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pc_valid_q   <= pc_valid_d;
         epoch_q      <= epoch_d;
         misalign_q   <= misalign_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
      end
   end

   assign bus.pc           = pc_q;
   assign bus.pc_valid     = pc_valid_q;
   assign bus.epoch        = epoch_q;
   assign bus.misalign_err = misalign_q;
endmodule
